camera_i2c_cfg_seq: RTL and testbench
=====================================

Name: camera_i2c_cfg_seq

Overview:
- Power-on register-configuration sequencer for the camera I2C write engine (sclk/sdin transfer block).
- Waits a power-up delay, then walks a register table of REG_NUM 32-bit words: slave addr, reg addr hi, reg addr lo, data.
- Issues one write transfer per entry, checks ack, and retries on NACK.
- Reports done and error status to the video pipeline. Runs in the I2C clock domain.

Parameters:
- REG_NUM, 256: table entries to send, indices 0..REG_NUM-1.
- IDX_W, 8: table index width, with 2^IDX_W >= REG_NUM.
- PWR_DLY, 400: clock_i2c cycles to wait after reset before the first transfer (20 ms at 20 kHz).
- GAP_CYC, 4: idle cycles between transfers, with start low. Minimum 2.
- MAX_RETRY, 3: retries per entry after a NACK.

Ports:
- clock_i2c  in  1  I2C engine clock, 20 kHz.
- camera_rstn  in  1  Asynchronous reset, active low.
- lut_index  out  IDX_W  Table address.
- lut_data  in  32  Table word; registered ROM, valid 1 cycle after lut_index changes.
- i2c_data  out  32  Word for the write engine; held stable while start=1.
- start  out  1  Transfer request to the write engine; held high for the whole transfer.
- tr_end  in  1  Engine transfer-complete flag; stays high until start falls.
- ack  in  1  Engine OR'd ack; 0 = all bytes acked, 1 = NACK.
- cfg_done  out  1  All entries sent; sticky until reset.
- cfg_err  out  1  At least one entry exhausted its retries; sticky.
- err_index  out  IDX_W  Index of the first failed entry.

Behaviour:
- Reset (asynchronous, active low) forces these values:
  - state=PWR_WAIT, start=0, i2c_data=0, lut_index=0.
  - cfg_done=0, cfg_err=0, err_index=0, all counters 0.
- Asserting reset mid-transfer drops start immediately; the engine shares camera_rstn and aborts too.
- States:
  - PWR_WAIT: count PWR_DLY cycles, then go to FETCH.
  - FETCH: drive lut_index=idx. Next cycle go to LOAD.
  - LOAD: capture i2c_data<=lut_data. Go to ARM.
  - ARM: wait until tr_end==0, then set start=1 and go to BUSY. This guards against a stale tr_end.
  - BUSY: hold start=1 and i2c_data.
    - On the first cycle with tr_end==1, sample ack into ack_r and set start=0.
    - Then go to CHECK.
  - CHECK, ack_r==0: clear retry_cnt and go to GAP with next=advance.
  - CHECK, ack_r==1 and retry_cnt<MAX_RETRY: increment retry_cnt and go to GAP with next=ARM. i2c_data is unchanged on retry.
  - CHECK, ack_r==1 and retry_cnt==MAX_RETRY:
    - Set cfg_err=1.
    - Set err_index=idx, only if cfg_err was previously 0.
    - Clear retry_cnt and advance (skip the entry).
  - GAP: count GAP_CYC cycles with start=0. This lets the engine reset its cycle counter and clear tr_end.
  - Advance: if idx==REG_NUM-1, go to DONE; else idx+1, then FETCH.
  - DONE: cfg_done=1, start=0. Stays here until reset.
- Per-entry latency: 3 cycles (FETCH/LOAD/ARM) + engine transfer (~42 cycles) + 1 (CHECK) + GAP_CYC.
- Bounds:
  - idx never wraps. REG_NUM=1 is legal.
  - retry_cnt width is clog2(MAX_RETRY+1). MAX_RETRY=0 means no retries.
  - A GAP_CYC below 2 is treated as 2.
- start is never asserted outside ARM→BUSY. If tr_end rises while not in BUSY, it is ignored.

Optional Feature:
- Macro: CAMERA_I2C_CFG_RESTART_EN.
- When defined, add input cfg_restart (1 bit, single-cycle pulse).
  - In DONE: clear cfg_done, cfg_err and err_index; set idx=0; go to FETCH (no power delay).
  - In any other state: latch the pulse and act on it at DONE entry.
- When undefined: no port, and DONE is terminal until reset.

Decomposition:
- Shared package camera_cfg_pkg holds:
  - state encoding constants;
  - the field offsets of the 32-bit table word (SLV 31:24, RAH 23:16, RAL 15:8, DAT 7:0);
  - the minimum-gap constant.
- Natural sub-module: camera_cfg_delay_cnt, a load/terminal-count down counter reused for PWR_DLY and GAP_CYC.

Test Plan (all with engine model + 4-entry ROM, PWR_DLY=10, GAP_CYC=4, MAX_RETRY=2):
- Release reset, slave always acks → first start rises at cycle 10+3; entries 0..3 are sent in order with i2c_data matching the ROM; cfg_done=1; cfg_err=0.
- Slave NACKs entry 1 twice, then acks → entry 1 is sent 3 times with identical i2c_data; cfg_err=0; cfg_done=1.
- Slave always NACKs entry 2 → 3 attempts; cfg_err=1; err_index=2; entry 3 is still sent; cfg_done=1.
- Assert camera_rstn low during BUSY of entry 1 → start=0 in the same cycle; after release, the sequence restarts at entry 0 following PWR_DLY.
- Hold tr_end high (stale) into ARM → start stays 0 until tr_end falls; there are always ≥4 start-low cycles between transfers.
- With CAMERA_I2C_CFG_RESTART_EN defined: pulse cfg_restart in DONE → cfg_done drops; all 4 entries are resent, with no PWR_DLY.

Source files
------------

// File: rtl/camera_cfg_pkg.sv
// camera_cfg_pkg: definitions shared by the camera I2C configuration sequencer.
//   - cfg_state_t : sequencer state encoding
//   - *_LSB       : byte offsets inside a 32-bit register-table word
//                   (SLV 31:24, RAH 23:16, RAL 15:8, DAT 7:0)
//   - MIN_GAP     : smallest allowed idle gap between transfers
package camera_cfg_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        FETCH    = 3'd1,
        LOAD     = 3'd2,
        ARM      = 3'd3,
        BUSY     = 3'd4,
        CHECK    = 3'd5,
        GAP      = 3'd6,
        DONE     = 3'd7
    } cfg_state_t;

    localparam int FIELD_W = 8;
    localparam int SLV_LSB = 24;
    localparam int RAH_LSB = 16;
    localparam int RAL_LSB = 8;
    localparam int DAT_LSB = 0;

    localparam int MIN_GAP = 2;

    function automatic logic [7:0] slv_of(input logic [31:0] w);
        return w[SLV_LSB +: FIELD_W];
    endfunction

    function automatic logic [7:0] rah_of(input logic [31:0] w);
        return w[RAH_LSB +: FIELD_W];
    endfunction

    function automatic logic [7:0] ral_of(input logic [31:0] w);
        return w[RAL_LSB +: FIELD_W];
    endfunction

    function automatic logic [7:0] dat_of(input logic [31:0] w);
        return w[DAT_LSB +: FIELD_W];
    endfunction

    function automatic int gap_cycles(input int g);
        return (g < MIN_GAP) ? MIN_GAP : g;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/camera_cfg_delay_cnt.sv
// camera_cfg_delay_cnt: load / terminal-count down counter.
//   clock_i2c   in  : I2C engine clock
//   camera_rstn in  : asynchronous reset, active low
//   load        in  : load load_val and start counting
//   load_val    in  : W bits, number of cycles after the load cycle minus 1
//   run         out : counter is active
//   tc          out : terminal count (active and count reached zero)
// A load of N holds tc off for N cycles and asserts it on the (N+1)th.
module camera_cfg_delay_cnt #(
    parameter int W = 9
) (
    input  logic         clock_i2c,
    input  logic         camera_rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         run,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clock_i2c or negedge camera_rstn) begin
        if (!camera_rstn) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            cnt <= load_val;
            run <= 1'b1;
        end else if (run) begin
            if (cnt == '0) begin
                run <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign tc = run && (cnt == '0);

endmodule

// File: rtl/camera_i2c_cfg_seq.sv
// camera_i2c_cfg_seq: power-on register configuration sequencer for the
// camera I2C write engine. Waits PWR_DLY cycles, then sends each of the
// REG_NUM table words through the write engine, retrying NACKed entries up
// to MAX_RETRY times.
//
// Ports:
//   clock_i2c   in  1      I2C engine clock
//   camera_rstn in  1      asynchronous reset, active low
//   lut_index   out IDX_W  table address (registered ROM, 1-cycle latency)
//   lut_data    in  32     table word
//   i2c_data    out 32     word for the write engine, stable while start=1
//   start       out 1      transfer request, high for the whole transfer
//   tr_end      in  1      engine transfer complete, high until start falls
//   ack         in  1      engine ack, 0 = all bytes acked, 1 = NACK
//   cfg_done    out 1      all entries sent (sticky)
//   cfg_err     out 1      some entry exhausted its retries (sticky)
//   err_index   out IDX_W  index of the first failed entry
//   cfg_restart in  1      (CAMERA_I2C_CFG_RESTART_EN only) rerun the table
//
// Optional macro: CAMERA_I2C_CFG_RESTART_EN adds cfg_restart; otherwise DONE
// is terminal until reset.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// PWR_WAIT | power-up delay after reset
// FETCH    | lut_index holds idx, ROM is reading
// LOAD     | capture the table word into i2c_data
// ARM      | wait for tr_end low, then raise start
// BUSY     | transfer in flight; first tr_end drops start and samples ack
// CHECK    | decide advance / retry / skip-with-error, load gap timer
// GAP      | idle with start low so the engine can clear tr_end
// DONE     | table finished
module camera_i2c_cfg_seq
    import camera_cfg_pkg::*;
#(
    parameter int REG_NUM   = 256,
    parameter int IDX_W     = 8,
    parameter int PWR_DLY   = 400,
    parameter int GAP_CYC   = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic             clock_i2c,
    input  logic             camera_rstn,
    output logic [IDX_W-1:0] lut_index,
    input  logic [31:0]      lut_data,
    output logic [31:0]      i2c_data,
    output logic             start,
    input  logic             tr_end,
    input  logic             ack,
`ifdef CAMERA_I2C_CFG_RESTART_EN
    input  logic             cfg_restart,
`endif
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [IDX_W-1:0] err_index
);

    localparam int GAP_EFF = gap_cycles(GAP_CYC);
    localparam int CW      = $clog2(max2(PWR_DLY, GAP_EFF) + 1);
    localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    // PWR_WAIT spends one cycle loading the timer, so the load value is two
    // short of the full delay to keep PWR_WAIT at exactly PWR_DLY cycles.
    localparam int PWR_LD  = (PWR_DLY > 2) ? (PWR_DLY - 2) : 0;

    localparam logic [CW-1:0]    PWR_LD_V  = CW'(PWR_LD);
    localparam logic [CW-1:0]    GAP_LD_V  = CW'(GAP_EFF - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(REG_NUM - 1);
    localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);

    cfg_state_t       state;
    logic [IDX_W-1:0] idx;
    logic [RW-1:0]    retry_cnt;
    logic             ack_r;
    logic             next_arm;
`ifdef CAMERA_I2C_CFG_RESTART_EN
    logic             restart_pend;
`endif

    logic             dly_load;
    logic [CW-1:0]    dly_val;
    logic             dly_run;
    logic             dly_tc;

    always_comb begin
        dly_load = 1'b0;
        dly_val  = GAP_LD_V;
        if (state == PWR_WAIT && !dly_run) begin
            dly_load = 1'b1;
            dly_val  = PWR_LD_V;
        end else if (state == CHECK) begin
            dly_load = 1'b1;
        end
    end

    camera_cfg_delay_cnt #(
        .W (CW)
    ) u_delay_cnt (
        .clock_i2c   (clock_i2c),
        .camera_rstn (camera_rstn),
        .load        (dly_load),
        .load_val    (dly_val),
        .run         (dly_run),
        .tc          (dly_tc)
    );

    assign lut_index = idx;

    always_ff @(posedge clock_i2c or negedge camera_rstn) begin
        if (!camera_rstn) begin
            state     <= PWR_WAIT;
            idx       <= '0;
            retry_cnt <= '0;
            ack_r     <= 1'b0;
            next_arm  <= 1'b0;
            start     <= 1'b0;
            i2c_data  <= '0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            err_index <= '0;
`ifdef CAMERA_I2C_CFG_RESTART_EN
            restart_pend <= 1'b0;
`endif
        end else begin
`ifdef CAMERA_I2C_CFG_RESTART_EN
            if (cfg_restart && state != DONE) begin
                restart_pend <= 1'b1;
            end
`endif
            case (state)
                PWR_WAIT: begin
                    if (dly_tc) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    i2c_data <= lut_data;
                    state    <= ARM;
                end
                ARM: begin
                    // A tr_end left over from the previous transfer must not
                    // be mistaken for completion of this one.
                    if (!tr_end) begin
                        start <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (tr_end) begin
                        ack_r <= ack;
                        start <= 1'b0;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    state <= GAP;
                    if (!ack_r) begin
                        retry_cnt <= '0;
                        next_arm  <= 1'b0;
                    end else if (retry_cnt < RETRY_MAX) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        next_arm  <= 1'b1;
                    end else begin
                        cfg_err <= 1'b1;
                        if (!cfg_err) begin
                            err_index <= idx;
                        end
                        retry_cnt <= '0;
                        next_arm  <= 1'b0;
                    end
                end
                GAP: begin
                    if (dly_tc) begin
                        if (next_arm) begin
                            state <= ARM;
                        end else if (idx == LAST_IDX) begin
                            cfg_done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    start <= 1'b0;
`ifdef CAMERA_I2C_CFG_RESTART_EN
                    if (cfg_restart || restart_pend) begin
                        restart_pend <= 1'b0;
                        cfg_done     <= 1'b0;
                        cfg_err      <= 1'b0;
                        err_index    <= '0;
                        idx          <= '0;
                        state        <= FETCH;
                    end
`endif
                end
                default: begin
                    start <= 1'b0;
                    state <= PWR_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_camera_i2c_cfg_seq.sv
// tb_camera_i2c_cfg_seq: randomized scoreboard bench for camera_i2c_cfg_seq
// with a 4-entry registered ROM and a behavioural write-engine model.
// The reference model expands each entry into the list of transfers the
// slave behaviour implies; a monitor pops that list on every start rise.
module tb_camera_i2c_cfg_seq;
    import camera_cfg_pkg::*;

    localparam int REG_NUM   = 4;
    localparam int IDX_W     = 2;
    localparam int PWR_DLY   = 10;
    localparam int GAP_CYC   = 4;
    localparam int MAX_RETRY = 2;

    logic             clock_i2c;
    logic             camera_rstn;
    logic [IDX_W-1:0] lut_index;
    logic [31:0]      lut_data;
    logic [31:0]      i2c_data;
    logic             start;
    logic             tr_end;
    logic             ack;
    logic             cfg_restart;
    logic             cfg_done;
    logic             cfg_err;
    logic [IDX_W-1:0] err_index;

    camera_i2c_cfg_seq #(
        .REG_NUM   (REG_NUM),
        .IDX_W     (IDX_W),
        .PWR_DLY   (PWR_DLY),
        .GAP_CYC   (GAP_CYC),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clock_i2c   (clock_i2c),
        .camera_rstn (camera_rstn),
        .lut_index   (lut_index),
        .lut_data    (lut_data),
        .i2c_data    (i2c_data),
        .start       (start),
        .tr_end      (tr_end),
        .ack         (ack),
`ifdef CAMERA_I2C_CFG_RESTART_EN
        .cfg_restart (cfg_restart),
`endif
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .err_index   (err_index)
    );

    int          vectors;
    int          miscompares;
    logic [31:0] rom [REG_NUM];
    int          nacks [REG_NUM];
    int          attempts [REG_NUM];
    logic [31:0] exp_q [$];
    bit          stale_mode;

    initial begin
        clock_i2c = 1'b0;
        forever #5 clock_i2c = ~clock_i2c;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Registered ROM: index seen at one edge, word available after the next.
    initial begin : rom_model
        logic [IDX_W-1:0] idx_q;
        lut_data = '0;
        forever begin
            @(negedge clock_i2c);
            idx_q = lut_index;
            @(posedge clock_i2c);
            #1;
            lut_data = rom[idx_q];
        end
    end

    // Write-engine model: random transfer length, tr_end held until start
    // falls (or longer in stale mode), ack from the per-entry NACK plan.
    initial begin : engine_model
        bit active;
        int lat;
        int stale_cnt;
        int e;
        active = 0; lat = 0; stale_cnt = 0;
        tr_end = 1'b0; ack = 1'b0;
        forever begin
            @(posedge clock_i2c);
            #1;
            if (!camera_rstn) begin
                active = 0; stale_cnt = 0; tr_end = 1'b0;
            end else if (active) begin
                if (!start) begin
                    active = 0;
                    if (stale_mode) stale_cnt = 10;
                    else tr_end = 1'b0;
                end else if (!tr_end) begin
                    if (lat > 0) begin
                        lat--;
                    end else begin
                        e = int'(ral_of(i2c_data)) % REG_NUM;
                        ack = (attempts[e] < nacks[e]);
                        attempts[e]++;
                        tr_end = 1'b1;
                    end
                end
            end else if (stale_cnt > 0) begin
                stale_cnt--;
                if (stale_cnt == 0) tr_end = 1'b0;
            end else if (start && !tr_end) begin
                active = 1;
                lat = $urandom_range(2, 7);
            end
        end
    end

    // Monitor: every start rise is one transfer presented to the engine.
    initial begin : monitor
        logic        start_p;
        logic        tr_end_p;
        logic [31:0] held;
        int          low_run;
        bit          seen_hi;
        start_p = 0; tr_end_p = 0; held = '0; low_run = 0; seen_hi = 0;
        forever begin
            @(negedge clock_i2c);
            if (!camera_rstn) begin
                start_p = 0; tr_end_p = 0; low_run = 0; seen_hi = 0;
            end else begin
                if (start && !start_p) begin
                    chk("start_with_stale_tr_end", {31'd0, tr_end_p}, 32'd0);
                    if (seen_hi) chk("start_low_gap_ge4", {31'd0, low_run >= 4}, 32'd1);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_transfer: got %0h want none at %0t", i2c_data, $time);
                    end else begin
                        chk("i2c_data", i2c_data, exp_q.pop_front());
                    end
                    held = i2c_data;
                end else if (start && start_p) begin
                    chk("i2c_data_hold", i2c_data, held);
                end
                if (start) begin
                    low_run = 0;
                    seen_hi = 1;
                end else begin
                    low_run++;
                end
                start_p  = start;
                tr_end_p = tr_end;
            end
        end
    end

    task automatic fill_rom();
        for (int i = 0; i < REG_NUM; i++) begin
            rom[i] = {8'($urandom()), 8'($urandom()), 8'(i), 8'($urandom())};
        end
    endtask

    task automatic set_nacks(input int n0, input int n1, input int n2, input int n3);
        nacks[0] = n0; nacks[1] = n1; nacks[2] = n2; nacks[3] = n3;
    endtask

    // Reference model: each entry yields min(nacks+1, MAX_RETRY+1) transfers.
    task automatic build_exp();
        exp_q.delete();
        for (int i = 0; i < REG_NUM; i++) begin
            attempts[i] = 0;
            for (int a = 0; a < ((nacks[i] > MAX_RETRY) ? MAX_RETRY + 1 : nacks[i] + 1); a++) begin
                exp_q.push_back(rom[i]);
            end
        end
    endtask

    function automatic int exp_err_index();
        for (int i = 0; i < REG_NUM; i++) begin
            if (nacks[i] > MAX_RETRY) return i;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(posedge clock_i2c);
        #1;
        camera_rstn = 1'b0;
        repeat (2) @(posedge clock_i2c);
        #1;
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_i2c_data", i2c_data, 32'd0);
        chk("rst_lut_index", {30'd0, lut_index}, 32'd0);
        chk("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
        chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        chk("rst_err_index", {30'd0, err_index}, 32'd0);
    endtask

    task automatic release_and_time();
        int n;
        camera_rstn = 1'b1;
        n = 0;
        while (n < 200) begin
            @(posedge clock_i2c);
            #1;
            n++;
            if (start) break;
        end
        chk("first_start_cycle", n, PWR_DLY + 3);
    endtask

    task automatic wait_done_check(input string tag);
        int n;
        int ei;
        n = 0;
        while (!cfg_done && n < 3000) begin
            @(posedge clock_i2c);
            #1;
            n++;
        end
        chk({tag, "_cfg_done"}, {31'd0, cfg_done}, 32'd1);
        repeat (5) @(posedge clock_i2c);
        #1;
        chk({tag, "_done_sticky"}, {31'd0, cfg_done}, 32'd1);
        chk({tag, "_start_idle"}, {31'd0, start}, 32'd0);
        chk({tag, "_all_sent"}, exp_q.size(), 32'd0);
        ei = exp_err_index();
        chk({tag, "_cfg_err"}, {31'd0, cfg_err}, {31'd0, ei >= 0});
        chk({tag, "_err_index"}, {30'd0, err_index}, (ei >= 0) ? ei : 0);
    endtask

    task automatic run_full(input string tag);
        do_reset();
        build_exp();
        release_and_time();
        wait_done_check(tag);
    endtask

    initial begin : main
        int n;
        vectors = 0;
        miscompares = 0;
        camera_rstn = 1'b0;
        cfg_restart = 1'b0;
        stale_mode = 0;
        for (int i = 0; i < REG_NUM; i++) attempts[i] = 0;
        fill_rom();

        set_nacks(0, 0, 0, 0);
        run_full("all_ack");

        set_nacks(0, 2, 0, 0);
        run_full("retry_then_ack");

        set_nacks(0, 0, 9, 0);
        run_full("exhaust_entry2");

        // Reset while entry 1 is in flight, then a full clean rerun.
        set_nacks(0, 0, 0, 0);
        do_reset();
        build_exp();
        release_and_time();
        n = 0;
        while (!(start && ral_of(i2c_data) == 8'd1) && n < 500) begin
            @(posedge clock_i2c);
            #1;
            n++;
        end
        chk("reached_busy_entry1", {31'd0, n < 500}, 32'd1);
        @(posedge clock_i2c);
        #3;
        camera_rstn = 1'b0;
        #1;
        chk("start_async_drop", {31'd0, start}, 32'd0);
        chk("lut_index_async_clear", {30'd0, lut_index}, 32'd0);
        repeat (2) @(posedge clock_i2c);
        #1;
        build_exp();
        release_and_time();
        wait_done_check("after_mid_reset");

        stale_mode = 1;
        set_nacks(0, 1, 0, 2);
        run_full("stale_tr_end");
        stale_mode = 0;

        for (int r = 0; r < 3; r++) begin
            fill_rom();
            set_nacks($urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            run_full("random");
        end

`ifdef CAMERA_I2C_CFG_RESTART_EN
        fill_rom();
        set_nacks(0, 0, 0, 0);
        run_full("pre_restart");
        fill_rom();
        build_exp();
        @(posedge clock_i2c);
        #1;
        cfg_restart = 1'b1;
        n = 0;
        while (n < 200) begin
            @(posedge clock_i2c);
            #1;
            n++;
            if (n == 1) begin
                cfg_restart = 1'b0;
                chk("restart_done_drop", {31'd0, cfg_done}, 32'd0);
            end
            if (start) break;
        end
        chk("restart_first_start", n, 4);
        wait_done_check("restart");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
